// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//   Bundles the control-unit request/response handshake and the word-wide RAM
//   port that mem_ctrl sits between.
//
//   Control-unit side : req, wr, size, sext, addr, wdata  -> controller
//                       ready, done, err, rdata           <- controller
//   RAM side          : ram_addr, ram_we, ram_be, ram_wdata <- controller
//                       ram_rdata                           -> controller
//
//   modport slave  : the controller's view (mem_ctrl uses this).
//   modport master : the environment's view (control unit plus RAM model).
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_BITS = 8
);

  logic                 req;
  logic                 wr;
  logic [1:0]           size;
  logic                 sext;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic                 ready;
  logic                 done;
  logic                 err;
  logic [31:0]          rdata;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_we;
  logic [3:0]           ram_be;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  modport master (
    output req, wr, size, sext, addr, wdata, ram_rdata,
    input  ready, done, err, rdata, ram_addr, ram_we, ram_be, ram_wdata
  );

  modport slave (
    input  req, wr, size, sext, addr, wdata, ram_rdata,
    output ready, done, err, rdata, ram_addr, ram_we, ram_be, ram_wdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Byte/half/word load-store controller in front of a 32-bit word RAM with a
//   fixed access latency of WAIT_CYCLES clocks. One request at a time: the
//   request is latched while ready=1, the RAM port is held stable for
//   WAIT_CYCLES cycles, then a one-cycle done pulse returns the (extended)
//   load data. Misaligned requests never touch the RAM and answer with
//   done=1/err=1 in the cycle right after acceptance.
//
//   Ports
//     clk   : single clock, all state changes on its rising edge
//     reset : asynchronous, active-low
//     bus   : mem_ctrl_if.slave (request handshake plus RAM port)
//
//   Parameters
//     WAIT_CYCLES : RAM access cycles per request (1..15)
//     ADDR_BITS   : RAM word-address width; byte addresses wrap modulo
//                   2^(ADDR_BITS+2)
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  mem_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e               state_q,    state_d;
  logic [3:0]           waitCnt_q,  waitCnt_d;
  logic                 wr_q,       wr_d;
  logic [1:0]           size_q,     size_d;
  logic                 sext_q,     sext_d;
  logic [1:0]           lane_q,     lane_d;
  logic                 ready_q,    ready_d;
  logic                 done_q,     done_d;
  logic                 err_q,      err_d;
  logic [31:0]          rdata_q,    rdata_d;
  logic [ADDR_BITS-1:0] ramAddr_q,  ramAddr_d;
  logic                 ramWe_q,    ramWe_d;
  logic [3:0]           ramBe_q,    ramBe_d;
  logic [31:0]          ramWdata_q, ramWdata_d;

  logic                 misaligned;
  logic [3:0]           storeBe;
  logic [31:0]          storeData;
  logic [7:0]           loadByte;
  logic [15:0]          loadHalf;
  logic [31:0]          loadData;

  // Byte-address bits above the RAM word address are deliberately dropped,
  // which is what makes addresses wrap around the RAM size.
  logic                 unusedAddrHi;
  assign unusedAddrHi = ^bus.addr[31:ADDR_BITS+2];

  // Decode the incoming request: alignment check, byte-lane enables and the
  // lane-replicated store data. Replicating the sub-word across every lane
  // means the RAM only has to honour ram_be, no shifting on its side.
  always_comb begin
    misaligned = (bus.size == 2'b11) ||
                 ((bus.size == 2'b01) && bus.addr[0]) ||
                 ((bus.size == 2'b00) && (bus.addr[1:0] != 2'b00));
    storeBe   = 4'b0000;
    storeData = 32'h0;
    case (bus.size)
      2'b00: begin
        storeBe   = 4'b1111;
        storeData = bus.wdata;
      end
      2'b01: begin
        storeBe   = bus.addr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{bus.wdata[15:0]}};
      end
      default: begin
        storeBe   = 4'b0001 << bus.addr[1:0];
        storeData = {4{bus.wdata[7:0]}};
      end
    endcase
  end

  // Pick the addressed lane out of the RAM word (little-endian: byte n lives
  // in bits 8n+7:8n) and sign- or zero-extend it using the latched request.
  always_comb begin
    loadByte = bus.ram_rdata[{lane_q, 3'b000} +: 8];
    loadHalf = lane_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    case (size_q)
      2'b00:   loadData = bus.ram_rdata;
      2'b01:   loadData = sext_q ? {{16{loadHalf[15]}}, loadHalf} : {16'h0, loadHalf};
      default: loadData = sext_q ? {{24{loadByte[7]}}, loadByte} : {24'h0, loadByte};
    endcase
  end

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here show up one edge later; that is why ram_we is raised
  // on the edge that enters the last ACCESS cycle rather than in it. done,
  // err, rdata and ram_we default to 0 so they can only ever be one-cycle
  // pulses.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    wr_d       = wr_q;
    size_d     = size_q;
    sext_d     = sext_q;
    lane_d     = lane_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = 32'h0;
    ramAddr_d  = ramAddr_q;
    ramWe_d    = 1'b0;
    ramBe_d    = ramBe_q;
    ramWdata_d = ramWdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          size_d  = bus.size;
          sext_d  = bus.sext;
          lane_d  = bus.addr[1:0];
          ready_d = 1'b0;
          if (misaligned) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = ACCESS;
            waitCnt_d  = WAIT_LOAD;
            ramAddr_d  = bus.addr[ADDR_BITS+1:2];
            ramBe_d    = bus.wr ? storeBe : 4'b1111;
            ramWdata_d = bus.wr ? storeData : 32'h0;
            ramWe_d    = bus.wr && (WAIT_LOAD == 4'd0);
          end
        end
      end

      ACCESS: begin
        if (waitCnt_q == 4'd0) begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = wr_q ? 32'h0 : loadData;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
          ramWe_d   = wr_q && (waitCnt_q == 4'd1);
        end
      end

      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      ERR: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so an in-flight access
  // (including a pending store) is killed immediately, without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      ramAddr_q  <= '0;
      ramWe_q    <= 1'b0;
      ramBe_q    <= 4'b0000;
      ramWdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      lane_q     <= lane_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ramAddr_q  <= ramAddr_d;
      ramWe_q    <= ramWe_d;
      ramBe_q    <= ramBe_d;
      ramWdata_q <= ramWdata_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_addr  = ramAddr_q;
  assign bus.ram_we    = ramWe_q;
  assign bus.ram_be    = ramBe_q;
  assign bus.ram_wdata = ramWdata_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: RAM access cycles per request, legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8: word-address width presented to the RAM.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 1: request from the control unit, sampled only while ready=1.
REQ-006 SHALL have port wr, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port size, input, 2: 00 word, 01 half, 10 byte, 11 illegal.
REQ-008 SHALL have port sext, input, 1: 1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-009 SHALL have port addr, input, 32: byte address.
REQ-010 SHALL have port wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port ready, output, 1: idle and able to accept a request.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1: misalignment flag, valid only with done.
REQ-014 SHALL have port rdata, output, 32: load result, valid only with done.
REQ-015 SHALL have port ram_addr, output, ADDR_BITS: word address, addr[ADDR_BITS+1:2].
REQ-016 SHALL have port ram_we, output, 1: RAM write enable.
REQ-017 SHALL have port ram_be, output, 4: byte-lane enables.
REQ-018 SHALL have port ram_wdata, output, 32: lane-replicated store data.
REQ-019 SHALL have port ram_rdata, input, 32: RAM read word, valid once ram_addr has been held for WAIT_CYCLES cycles.

Function
REQ-020 SHALL implement the states IDLE, ACCESS, RESP and ERR, with all outputs registered.
REQ-021 IDLE SHALL drive ready=1; on an edge with req=1, the block SHALL latch wr, size, sext, addr and wdata and drop ready.
REQ-022 An access SHALL be misaligned if size=11, or size=01 with addr[0]=1, or size=00 with addr[1:0]!=00.
REQ-023 A misaligned request SHALL go IDLE->ERR; ERR SHALL last 1 cycle with done=1, err=1 and rdata=0, SHALL never assert ram_we, then SHALL return to IDLE.
REQ-024 An aligned request SHALL go IDLE->ACCESS and load a counter with WAIT_CYCLES-1.
REQ-025 ACCESS SHALL hold ram_addr, ram_be and ram_wdata stable and decrement the counter each cycle.
REQ-026 ACCESS SHALL go to RESP on the edge where the counter is 0.
REQ-027 If accepted on edge k, done SHALL be high exactly during the cycle between edges k+WAIT_CYCLES and k+WAIT_CYCLES+1.
REQ-028 ready SHALL be high again after edge k+WAIT_CYCLES+1.
REQ-029 For stores, ram_we SHALL be high only in the final ACCESS cycle.
REQ-030 For stores, ram_be SHALL be 1111 for word, 0011<<addr[1] times 2 for half, and 0001<<addr[1:0] for byte.
REQ-031 For stores, ram_wdata SHALL replicate the byte or half across all lanes.
REQ-032 For loads, ram_we SHALL be 0 and ram_be 1111.
REQ-033 For loads, ram_rdata SHALL be captured on the ACCESS->RESP edge.
REQ-034 Lane selection SHALL be little-endian: byte n = bits 8n+7:8n.
REQ-035 Sub-word loads SHALL extend per sext; rdata SHALL be 0 during store done.
REQ-036 req SHALL be ignored while ready=0, with no queueing.
REQ-037 A request in the same cycle as done SHALL be ignored; the next accept is possible only when ready=1.
REQ-038 Address bits above ADDR_BITS+1 SHALL be ignored, so addresses wrap modulo 2^(ADDR_BITS+2).

Reset
REQ-039 reset=0 SHALL immediately, without waiting for a clock edge, force state IDLE, ready=1, and done, err, ram_we, ram_be, ram_addr, ram_wdata, rdata and the counter to 0.
REQ-040 A reset mid-ACCESS SHALL abort the access with no done pulse; a store aborted before its final ACCESS cycle SHALL produce no RAM write.
REQ-041 After reset is released, the first rising edge with req=1 SHALL be accepted.

Verification
REQ-042 Load word, addr=0x10, ram_rdata=0xDEADBEEF, WAIT_CYCLES=2 -> ram_addr=0x04, done high 2 edges after accept, rdata=0xDEADBEEF, err=0.
REQ-043 Load byte, addr=0x13, sext=1, ram_rdata=0x80FF_0000 -> rdata=0xFFFFFF80; with sext=0 -> 0x00000080.
REQ-044 Store half, addr=0x06, wdata=0x0000ABCD -> ram_be=1100, ram_wdata=0xABCDABCD, ram_we high exactly 1 cycle, done follows.
REQ-045 Load word, addr=0x02 -> done=1, err=1 one cycle after accept, ram_we never high, ready returns next cycle.
REQ-046 Store word, reset driven low during the first ACCESS cycle -> ram_we stays 0, no done, ready=1 asynchronously; a new request is accepted after release.
REQ-047 req held high continuously -> back-to-back accesses spaced WAIT_CYCLES+2 cycles, with no request accepted while ready=0.
